// File: rtl/pc_sequencer_if.sv
// Link between the fetch/decode/execute sequencer and its surroundings: run and ROM word in,
// PC control plus execute-stage state out.
interface pc_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
);
  logic                    run;
  logic [OPC_W+ADDR_W-1:0] instr;
  logic                    pc_rst;
  logic                    pc_enable;
  logic                    pc_jmp;
  logic [ADDR_W-1:0]       pc_jmploc;
  logic [ADDR_W-1:0]       acc;
  logic                    flag_z;
  logic                    flag_c;
  logic [ADDR_W-1:0]       out_data;
  logic                    out_valid;
  logic                    halted;
  logic                    illegal;

  modport master (
    input  run, instr,
    output pc_rst, pc_enable, pc_jmp, pc_jmploc,
    output acc, flag_z, flag_c, out_data, out_valid, halted, illegal
  );

  modport slave (
    output run, instr,
    input  pc_rst, pc_enable, pc_jmp, pc_jmploc,
    input  acc, flag_z, flag_c, out_data, out_valid, halted, illegal
  );
endinterface

// File: rtl/pc_sequencer.sv
// Three-cycle fetch/decode/execute controller for a 4-bit PC, with accumulator, Z/C flags
// and an output register as the execute stage.
module pc_sequencer #(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.master bus
);

  localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

  typedef enum logic [2:0] {S_INIT, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t                  state;
  logic [OPC_W+ADDR_W-1:0] ir;
  logic [ADDR_W-1:0]       acc;
  logic [ADDR_W-1:0]       out_data;
  logic                    flag_z;
  logic                    flag_c;
  logic                    out_valid;
  logic                    halted;
  logic                    illegal;
  logic                    pc_rst;
  logic                    pc_enable;
  logic                    pc_jmp;

  logic [OPC_W-1:0]        opcode;
  logic [ADDR_W-1:0]       imm;
  logic [ADDR_W:0]         sum;
  logic [ADDR_W-1:0]       diff;
  logic                    jump_taken;

  assign opcode = ir[OPC_W+ADDR_W-1:ADDR_W];
  assign imm    = ir[ADDR_W-1:0];
  assign sum    = {1'b0, acc} + {1'b0, imm};
  assign diff   = acc - imm;

  // Flags only change at the end of EXEC, so their DECODE-cycle value is the one EXEC sees.
  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = flag_z;
      OP_JC:   jump_taken = flag_c;
      default: jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      ir        <= '0;
      acc       <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      // NOTE: pc_rst resets high so the PC is held in reset alongside us and INIT shows it for one cycle.
      pc_rst    <= 1'b1;
      pc_enable <= 1'b0;
      pc_jmp    <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle; only the branch that needs one raises it.
      pc_rst    <= 1'b0;
      pc_enable <= 1'b0;
      pc_jmp    <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        S_INIT: begin
          state     <= S_FETCH;
          pc_enable <= bus.run;
        end
        S_FETCH: begin
          // NOTE: pc_enable carries run from one cycle earlier, keeping the PC clock gate glitch-free.
          if (pc_enable) begin
            ir    <= bus.instr;
            state <= S_DECODE;
          end else begin
            pc_enable <= bus.run;
          end
        end
        S_DECODE: begin
          if (opcode == OP_HLT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state  <= S_EXEC;
            pc_jmp <= jump_taken;
          end
        end
        S_EXEC: begin
          state     <= S_FETCH;
          pc_enable <= bus.run;
          case (opcode)
            OP_NOP, OP_JMP, OP_JZ, OP_JC, OP_HLT: ;
            OP_LDI: begin
              acc    <= imm;
              flag_z <= (imm == '0);
            end
            OP_ADD: begin
              acc    <= sum[ADDR_W-1:0];
              flag_c <= sum[ADDR_W];
              flag_z <= (sum[ADDR_W-1:0] == '0);
            end
            OP_SUB: begin
              acc    <= diff;
              flag_c <= (acc < imm);
              flag_z <= (diff == '0);
            end
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
            end
            default: illegal <= 1'b1;
          endcase
        end
        S_HALT: halted <= 1'b1;
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.pc_rst    = pc_rst;
  assign bus.pc_enable = pc_enable;
  assign bus.pc_jmp    = pc_jmp;
  assign bus.pc_jmploc = imm;
  assign bus.acc       = acc;
  assign bus.flag_z    = flag_z;
  assign bus.flag_c    = flag_c;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.halted    = halted;
  assign bus.illegal   = illegal;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a 4-bit PC and ROM around the DUT, an instruction-level reference
// model filling scoreboard queues, and a monitor checking fetches and output strobes.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pc;
  logic [3:0] pc_seed;
  logic       pc_load;
  logic [7:0] rom [16];
  logic       mon_en;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] pc;
    logic [3:0] acc;
    logic       z;
    logic       c;
    logic       ill;
  } fetch_t;

  fetch_t     exp_fetch [$];
  logic [3:0] exp_out   [$];

  pc_sequencer_if #(.ADDR_W(4), .OPC_W(4)) bus ();

  pc_sequencer #(.ADDR_W(4), .OPC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Program counter the sequencer drives; pc_load lets the bench scramble it before reset release.
  always @(posedge clk) begin
    if (pc_load)            pc <= pc_seed;
    else if (bus.pc_rst)    pc <= 4'd0;
    else if (bus.pc_jmp)    pc <= bus.pc_jmploc;
    else if (bus.pc_enable) pc <= pc + 4'd1;
  end

  assign bus.instr = rom[pc];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int val);
    total++;
    bad++;
    $display("FAIL %s: value %0d", name, val);
  endtask

  // Instruction-level model: architectural state seen at each fetch, plus OUT values.
  task automatic model_prog(input int n, output bit halts);
    int mpc = 0, macc = 0, op, imm, s;
    bit z = 0, c = 0, ill = 0;
    halts = 0;
    for (int i = 0; i < n; i++) begin
      exp_fetch.push_back('{4'(mpc), 4'(macc), z, c, ill});
      op  = int'(rom[mpc]) / 16;
      imm = int'(rom[mpc]) % 16;
      mpc = (mpc + 1) % 16;
      case (op)
        0: ;
        1: begin macc = imm; z = (imm == 0); end
        2: begin s = macc + imm; c = (s > 15); macc = s % 16; z = (macc == 0); end
        3: begin c = (macc < imm); macc = (macc - imm + 16) % 16; z = (macc == 0); end
        4: mpc = imm;
        5: if (z) mpc = imm;
        6: if (c) mpc = imm;
        7: exp_out.push_back(4'(macc));
        15: begin halts = 1; return; end
        default: ill = 1;
      endcase
    end
    exp_fetch.push_back('{4'(mpc), 4'(macc), z, c, ill});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.pc_enable) begin
        if (exp_fetch.size() == 0) fail_now("fetch_unexpected_pc", int'(pc));
        else begin
          fetch_t r;
          r = exp_fetch.pop_front();
          check("fetch_pc", 32'(pc), 32'(r.pc));
          check("fetch_acc_z_c_ill", {bus.acc, bus.flag_z, bus.flag_c, bus.illegal},
                {r.acc, r.z, r.c, r.ill});
        end
      end
      if (bus.out_valid) begin
        if (exp_out.size() == 0) fail_now("out_unexpected_data", int'(bus.out_data));
        else check("out_data", 32'(bus.out_data), 32'(exp_out.pop_front()));
      end
      if (bus.pc_enable || bus.pc_jmp)
        check("enable_jmp_exclusive", 32'(bus.pc_enable & bus.pc_jmp), 32'd0);
    end
  end

  // Leaves rst low with a random PC loaded; returns just after a rising edge.
  task automatic apply_reset();
    mon_en = 0;
    rst    = 1'b0;
    exp_fetch.delete();
    exp_out.delete();
    repeat (2) @(posedge clk);
    #1 check("reset_state",
             {bus.acc, bus.flag_z, bus.flag_c, bus.out_data, bus.out_valid, bus.halted,
              bus.illegal, bus.pc_enable, bus.pc_jmp}, 32'd0);
    @(negedge clk);
    pc_seed = 4'($urandom);
    pc_load = 1'b1;
    @(posedge clk);
    #1 pc_load = 1'b0;
  endtask

  task automatic release_reset(input bit monitor);
    rst    = 1'b1;
    mon_en = monitor;
  endtask

  task automatic stall_check();
    logic [3:0] cap_pc, cap_acc;
    bus.run = 1'b0;
    repeat (4) @(negedge clk);
    cap_pc  = pc;
    cap_acc = bus.acc;
    repeat (10) begin
      @(negedge clk);
      check("stall_en_pc_acc", {bus.pc_enable, pc, bus.acc}, {1'b0, cap_pc, cap_acc});
    end
    bus.run = 1'b1;
  endtask

  task automatic run_prog(input bit exp_halt, input bit rand_run, input int stall_cyc,
                          output int jmp_cnt, output logic [3:0] jmp_loc);
    int cyc = 0;
    bit done = 0;
    jmp_cnt = 0;
    jmp_loc = 4'd0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (bus.pc_jmp) begin
        jmp_cnt++;
        jmp_loc = bus.pc_jmploc;
      end
      if (cyc == stall_cyc) stall_check();
      if (rand_run) bus.run = ($urandom_range(0, 3) != 0);
      done = (exp_fetch.size() == 0) && (exp_out.size() == 0) && (!exp_halt || bus.halted);
    end
    if (!done) fail_now("program_timeout_cycles", cyc);
    bus.run = 1'b1;
    check("halted_at_end", 32'(bus.halted), 32'(exp_halt));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  initial begin
    int         jc;
    logic [3:0] jl;
    bit         halts;
    bit         got;

    rst     = 1'b0;
    pc_load = 1'b0;
    pc_seed = 4'd0;
    mon_en  = 0;
    bus.run = 1'b1;
    clear_rom();

    // All-NOP ROM from a scrambled PC: one pc_rst cycle, then an enable every third cycle.
    apply_reset();
    clear_rom();
    model_prog(8, halts);
    release_reset(1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("startup_rst_en", {bus.pc_rst, bus.pc_enable}, {k == 0, (k % 3) == 1});
    end
    run_prog(halts, 0, 0, jc, jl);
    check("nop_jmp_count", 32'(jc), 32'd0);

    // LDI 9, ADD 9 (carry), OUT, with a 10-cycle run stall after the first instruction.
    apply_reset();
    clear_rom();
    rom[0] = 8'h19; rom[1] = 8'h29; rom[2] = 8'h70; rom[3] = 8'hF0;
    model_prog(10, halts);
    release_reset(1);
    run_prog(halts, 0, 4, jc, jl);
    check("add_out_data", 32'(bus.out_data), 32'd2);

    // LDI 3, SUB 3, JZ 10 taken, HLT at 10, then the PC stays frozen.
    apply_reset();
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'h33; rom[2] = 8'h5A; rom[10] = 8'hF0;
    model_prog(10, halts);
    release_reset(1);
    run_prog(halts, 0, 0, jc, jl);
    check("jz_jmp_count", 32'(jc), 32'd1);
    check("jz_jmp_loc", 32'(jl), 32'd10);
    begin
      logic [3:0] cap;
      cap = pc;
      repeat (24) begin
        @(negedge clk);
        bus.run = 1'($urandom);
        check("halt_frozen", {pc, bus.pc_enable, bus.pc_jmp, bus.pc_rst, bus.halted},
              {cap, 4'b0001});
      end
      bus.run = 1'b1;
    end

    // JC not taken at 5, JMP 15, NOP at 15 wraps to 0.
    apply_reset();
    clear_rom();
    rom[0] = 8'h11; rom[5] = 8'h6C; rom[6] = 8'h4F; rom[12] = 8'h1E; rom[15] = 8'h00;
    model_prog(12, halts);
    release_reset(1);
    run_prog(halts, 0, 0, jc, jl);
    check("wrap_jmp_count", 32'(jc), 32'd1);
    check("wrap_jmp_loc", 32'(jl), 32'd15);

    // Asynchronous reset in the EXEC cycle of a JMP.
    apply_reset();
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h47; rom[7] = 8'hF0;
    release_reset(0);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.pc_jmp;
    end
    if (!got) fail_now("jmp_never_seen_cycles", 40);
    check("acc_before_reset", 32'(bus.acc), 32'd5);
    #2 rst = 1'b0;
    #1 check("async_reset_jmp_acc", {bus.pc_jmp, bus.acc}, 32'd0);

    // Restart from PC 0; opcode 9 flags illegal and leaves acc alone.
    apply_reset();
    clear_rom();
    rom[0] = 8'h16; rom[1] = 8'h93; rom[2] = 8'h70; rom[3] = 8'hF0;
    model_prog(10, halts);
    release_reset(1);
    run_prog(halts, 0, 0, jc, jl);
    check("illegal_sticky", 32'(bus.illegal), 32'd1);
    check("illegal_acc", 32'(bus.acc), 32'd6);

    // Random programs with random run gaps and one forced stall each.
    for (int t = 0; t < 8; t++) begin
      apply_reset();
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
      model_prog(30, halts);
      release_reset(1);
      run_prog(halts, 1, $urandom_range(5, 40), jc, jl);
    end

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
